ttl_74ls191: RTL

//  Presettable synchronous up/down binary counter with terminal-count and

---
 rtl/ttl_pkg.sv | 19 +
 rtl/ttl_74ls191.sv | 57 +++++
 2 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL counter library.
//   TTL_CNT_UP / TTL_CNT_DOWN : encodings of the D_U direction pin
//   tc(q, dir, width)         : terminal-count detect for a width-bit value;
//                               all-ones when counting up, zero when counting down
package ttl_pkg;

    localparam logic TTL_CNT_UP   = 1'b0;
    localparam logic TTL_CNT_DOWN = 1'b1;

    function automatic logic tc(input logic [31:0] q, input logic dir, input int unsigned width);
        logic [31:0] mask;
        mask = 32'((64'd1 << width) - 64'd1);
        if (dir == TTL_CNT_DOWN)
            return (q & mask) == 32'd0;
        else
            return (q & mask) == mask;
    endfunction

endpackage

// File: rtl/ttl_74ls191.sv
// Presettable synchronous up/down binary counter with terminal-count and
// ripple carry/borrow outputs, plus an asynchronous clear.
//   _A       : clock, all synchronous actions on the falling edge
//   R        : asynchronous active-high clear
//   _LOAD    : active-low synchronous parallel load of D
//   _CTEN    : active-low count enable
//   D_U      : direction, 0 = up, 1 = down
//   D        : preset data
//   Q        : counter state
//   MAX_MIN  : terminal count for the current direction
//   _RCO     : active-low carry/borrow, low when at terminal count and enabled
//   VCC, GND : power pins, modelling only
module ttl_74ls191
    import ttl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             _A,
    input  logic             R,
    input  logic             _LOAD,
    input  logic             _CTEN,
    input  logic             D_U,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             MAX_MIN,
    output logic             _RCO,
    input  logic             VCC,
    input  logic             GND
);

    logic unused_pwr;
    assign unused_pwr = VCC ^ GND;

    always_ff @(negedge _A or posedge R) begin
        if (R) begin
            Q <= '0;
        end else if (!_LOAD) begin
            Q <= D;
        end else begin
            // An unknown enable or direction must not be resolved to a
            // plausible value; anything other than clean 0/1 poisons Q.
            case ({_CTEN, D_U})
                {1'b0, TTL_CNT_UP}:   Q <= Q + 1'b1;
                {1'b0, TTL_CNT_DOWN}: Q <= Q - 1'b1;
                {1'b1, TTL_CNT_UP},
                {1'b1, TTL_CNT_DOWN}: Q <= Q;
                default:              Q <= 'x;
            endcase
        end
    end

    // Purely combinational so a cascade's next stage sees the enable in the
    // same cycle and all stages step on one shared edge.
    assign MAX_MIN = tc(32'(Q), D_U, WIDTH);
    assign _RCO    = ~(MAX_MIN & ~_CTEN);

endmodule
